// File: rtl/vmem_pkg.sv
// Shared constants, control codes and FSM state encoding for the character
// video memory write path.
package vmem_pkg;

    localparam int unsigned ROWS       = 30;
    localparam int unsigned COLS       = 70;
    localparam int unsigned ROW_STRIDE = 128;
    localparam int unsigned ADDR_BASE  = 4;
    localparam logic [7:0]  BLANK      = 8'h20;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;

    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
    localparam logic [6:0] COL_LAST = 7'(COLS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUSY,
        ST_SCROLL_REG,
        ST_CLEAR_LINE,
        ST_CLEAR_REG,
        ST_CLEAR_FILL
    } state_t;

    function automatic logic [4:0] next_line(input logic [4:0] line);
        return (line == ROW_LAST) ? 5'd0 : line + 5'd1;
    endfunction

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/vmem_console_writer_if.sv
// Byte-stream input and vmem write port of the console writer; the master side
// is the character source, the slave side is the writer itself.
interface vmem_console_writer_if;

    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic [19:0] wraddr;
    logic [7:0]  datain;
    logic        we;

    modport master (
        output char_valid, char_data,
        input  char_ready, wraddr, datain, we
    );

    modport slave (
        input  char_valid, char_data,
        output char_ready, wraddr, datain, we
    );

endinterface

// File: rtl/vmem_cell_addr.sv
// Combinational vmem cell address: physical row = (row + zero_line) mod ROWS,
// address = ADDR_BASE + prow*ROW_STRIDE + col.
module vmem_cell_addr
    import vmem_pkg::*;
(
    input  logic [4:0]  row,
    input  logic [4:0]  zero_line,
    input  logic [6:0]  col,
    output logic [19:0] addr
);

    logic [5:0] sum;
    logic [4:0] prow;

    always_comb begin
        sum  = {1'b0, row} + {1'b0, zero_line};
        // Both operands are below ROWS, so one conditional subtract is a full modulo.
        prow = (sum >= 6'(ROWS)) ? 5'(sum - 6'(ROWS)) : sum[4:0];
        addr = 20'(ADDR_BASE) + 20'(prow) * 20'(ROW_STRIDE) + 20'(col);
    end

endmodule

// File: rtl/vmem_console_writer.sv
// Console write controller: cursor, wrap, CR/LF/BS, clear-screen and hardware
// scroll via the zero_line register. Define CONSOLE_INIT_CLEAR_EN to clear on reset.
module vmem_console_writer
    import vmem_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    vmem_console_writer_if.slave        bus,
    output logic [4:0]                  cursor_row,
    output logic [6:0]                  cursor_col,
    output logic [4:0]                  zero_line
);

`ifdef CONSOLE_INIT_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR_REG;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t      state, state_n;
    logic        we_q, we_n;
    logic [19:0] wraddr_q, wraddr_n;
    logic [7:0]  datain_q, datain_n;
    logic        ready_q, ready_n;
    logic [4:0]  row_n, zl_n;
    logic [6:0]  col_n;
    logic [4:0]  fill_row, fill_row_n;
    logic [6:0]  fill_col, fill_col_n;

    logic [4:0]  a_row, a_zl;
    logic [6:0]  a_col;
    logic [19:0] cell_addr;
    logic        handshake;

    assign bus.we         = we_q;
    assign bus.wraddr     = wraddr_q;
    assign bus.datain     = datain_q;
    assign bus.char_ready = ready_q;

    assign handshake = bus.char_valid && ready_q;

    // IDLE addresses the cursor cell (or the cell left of it for BS); the
    // clear states address their own row/col walker in physical coordinates.
    always_comb begin
        if (state == ST_IDLE) begin
            a_row = cursor_row;
            a_zl  = zero_line;
            a_col = (bus.char_data == CH_BS) ? 7'(cursor_col - 7'd1) : cursor_col;
        end else begin
            a_row = fill_row;
            a_zl  = 5'd0;
            a_col = fill_col;
        end
    end

    vmem_cell_addr u_cell_addr (
        .row       (a_row),
        .zero_line (a_zl),
        .col       (a_col),
        .addr      (cell_addr)
    );

    // NOTE: every register gets its hold value first, so no path through the
    // case statement can leave a variable unassigned and infer a latch.
    always_comb begin
        state_n    = state;
        we_n       = 1'b0;
        wraddr_n   = wraddr_q;
        datain_n   = datain_q;
        row_n      = cursor_row;
        col_n      = cursor_col;
        zl_n       = zero_line;
        fill_row_n = fill_row;
        fill_col_n = fill_col;

        unique case (state)
            ST_IDLE: begin
                if (handshake) begin
                    if (is_printable(bus.char_data)) begin
                        we_n     = 1'b1;
                        wraddr_n = cell_addr;
                        datain_n = bus.char_data;
                        if (cursor_col == COL_LAST) begin
                            col_n = 7'd0;
                            if (cursor_row < ROW_LAST) begin
                                row_n   = cursor_row + 5'd1;
                                state_n = ST_BUSY;
                            end else begin
                                state_n = ST_SCROLL_REG;
                            end
                        end else begin
                            col_n   = cursor_col + 7'd1;
                            state_n = ST_BUSY;
                        end
                    end else begin
                        unique case (bus.char_data)
                            CH_LF: begin
                                col_n = 7'd0;
                                if (cursor_row < ROW_LAST) begin
                                    row_n   = cursor_row + 5'd1;
                                    state_n = ST_BUSY;
                                end else begin
                                    state_n = ST_SCROLL_REG;
                                end
                            end
                            CH_CR: col_n = 7'd0;
                            CH_BS: begin
                                if (cursor_col != 7'd0) begin
                                    col_n    = cursor_col - 7'd1;
                                    we_n     = 1'b1;
                                    wraddr_n = cell_addr;
                                    datain_n = BLANK;
                                    state_n  = ST_BUSY;
                                end
                            end
                            CH_FF:   state_n = ST_CLEAR_REG;
                            default: ;
                        endcase
                    end
                end
            end

            ST_BUSY: state_n = ST_IDLE;

            ST_SCROLL_REG: begin
                // The line that was on top becomes the new bottom line.
                we_n       = 1'b1;
                wraddr_n   = 20'd0;
                datain_n   = {3'b000, next_line(zero_line)};
                zl_n       = next_line(zero_line);
                fill_row_n = zero_line;
                fill_col_n = 7'd0;
                state_n    = ST_CLEAR_LINE;
            end

            ST_CLEAR_LINE: begin
                we_n     = 1'b1;
                wraddr_n = cell_addr;
                datain_n = BLANK;
                if (fill_col == COL_LAST) begin
                    fill_col_n = 7'd0;
                    state_n    = ST_IDLE;
                end else begin
                    fill_col_n = fill_col + 7'd1;
                end
            end

            ST_CLEAR_REG: begin
                we_n       = 1'b1;
                wraddr_n   = 20'd0;
                datain_n   = 8'd0;
                zl_n       = 5'd0;
                fill_row_n = 5'd0;
                fill_col_n = 7'd0;
                state_n    = ST_CLEAR_FILL;
            end

            ST_CLEAR_FILL: begin
                we_n     = 1'b1;
                wraddr_n = cell_addr;
                datain_n = BLANK;
                if (fill_col == COL_LAST) begin
                    fill_col_n = 7'd0;
                    if (fill_row == ROW_LAST) begin
                        row_n   = 5'd0;
                        col_n   = 7'd0;
                        state_n = ST_IDLE;
                    end else begin
                        fill_row_n = fill_row + 5'd1;
                    end
                end else begin
                    fill_col_n = fill_col + 7'd1;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: ready is derived from the next state so it is registered alongside
    // the write it accompanies, not decoded from the current state.
    assign ready_n = (state_n == ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RESET_STATE;
            we_q       <= 1'b0;
            wraddr_q   <= 20'd0;
            datain_q   <= 8'd0;
            ready_q    <= (RESET_STATE == ST_IDLE);
            cursor_row <= 5'd0;
            cursor_col <= 7'd0;
            zero_line  <= 5'd0;
            fill_row   <= 5'd0;
            fill_col   <= 7'd0;
        end else begin
            state      <= state_n;
            we_q       <= we_n;
            wraddr_q   <= wraddr_n;
            datain_q   <= datain_n;
            ready_q    <= ready_n;
            cursor_row <= row_n;
            cursor_col <= col_n;
            zero_line  <= zl_n;
            fill_row   <= fill_row_n;
            fill_col   <= fill_col_n;
        end
    end

endmodule

// File: tb/tb_vmem_console_writer.sv
// Directed, table-driven bench for vmem_console_writer: logs every vmem write
// and compares against hand-computed addresses, data and cursor state.
module tb_vmem_console_writer;
    import vmem_pkg::*;

    typedef struct packed {
        logic [19:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [7:0]  c;
        int          nw;
        logic [19:0] addr;
        logic [7:0]  data;
        logic [4:0]  row;
        logic [6:0]  col;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] cursor_row;
    logic [6:0] cursor_col;
    logic [4:0] zero_line;

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t log_q[$];

    always #5 clk = ~clk;

    vmem_console_writer_if bus ();

    vmem_console_writer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .zero_line  (zero_line)
    );

    always @(negedge clk) begin
        if (bus.we === 1'b1) log_q.push_back(wr_t'({bus.wraddr, bus.datain}));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        log_q.delete();
    endtask

    task automatic send(input logic [7:0] c);
        int n = 0;
        while (bus.char_ready !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (bus.char_ready !== 1'b1) check("send_ready_timeout", 32'(bus.char_ready), 32'd1);
        bus.char_valid = 1'b1;
        bus.char_data  = c;
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.char_ready !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (bus.char_ready !== 1'b1) check("idle_timeout", 32'(bus.char_ready), 32'd1);
    endtask

    // Checks COLS consecutive blank writes starting at log index idx.
    task automatic check_blank_row(input string name, input int idx, input int base);
        int bad = 0;
        for (int i = 0; i < int'(COLS); i++) begin
            if (log_q[idx + i] !== wr_t'({20'(base + i), BLANK})) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{8'h62, 1, 20'd5,   8'h62, 5'd0, 7'd2};
        vecs[1]  = '{CH_BS, 1, 20'd5,   BLANK, 5'd0, 7'd1};
        vecs[2]  = '{CH_CR, 0, 20'd0,   8'h00, 5'd0, 7'd0};
        vecs[3]  = '{CH_BS, 0, 20'd0,   8'h00, 5'd0, 7'd0};
        vecs[4]  = '{8'h01, 0, 20'd0,   8'h00, 5'd0, 7'd0};
        vecs[5]  = '{CH_LF, 0, 20'd0,   8'h00, 5'd1, 7'd0};
        vecs[6]  = '{8'h7E, 1, 20'd132, 8'h7E, 5'd1, 7'd1};
        vecs[7]  = '{8'h7F, 0, 20'd0,   8'h00, 5'd1, 7'd1};
        vecs[8]  = '{8'h1F, 0, 20'd0,   8'h00, 5'd1, 7'd1};
        vecs[9]  = '{8'h20, 1, 20'd133, 8'h20, 5'd1, 7'd2};
        vecs[10] = '{8'h78, 1, 20'd134, 8'h78, 5'd1, 7'd3};
        vecs[11] = '{CH_BS, 1, 20'd134, BLANK, 5'd1, 7'd2};

        do_reset();
        check("rst_we",         32'(bus.we),         32'd0);
        check("rst_wraddr",     32'(bus.wraddr),     32'd0);
        check("rst_datain",     32'(bus.datain),     32'd0);
        check("rst_ready",      32'(bus.char_ready), 32'd1);
        check("rst_row",        32'(cursor_row),     32'd0);
        check("rst_col",        32'(cursor_col),     32'd0);
        check("rst_zero_line",  32'(zero_line),      32'd0);

        // 'A': write visible the cycle after handshake, ready low for one cycle.
        send(8'h41);
        check("a_we",     32'(bus.we),         32'd1);
        check("a_wraddr", 32'(bus.wraddr),     32'd4);
        check("a_datain", 32'(bus.datain),     32'h41);
        check("a_ready0", 32'(bus.char_ready), 32'd0);
        check("a_col",    32'(cursor_col),     32'd1);
        @(posedge clk);
        #1;
        check("a_ready1", 32'(bus.char_ready), 32'd1);
        check("a_we_off", 32'(bus.we),         32'd0);
        log_q.delete();

        for (int i = 0; i < 12; i++) begin
            log_q.delete();
            send(vecs[i].c);
            wait_idle();
            check($sformatf("vec%0d_nwr", i), 32'(log_q.size()), 32'(vecs[i].nw));
            if (vecs[i].nw == 1) begin
                check($sformatf("vec%0d_addr", i), 32'(log_q[0].addr), 32'(vecs[i].addr));
                check($sformatf("vec%0d_data", i), 32'(log_q[0].data), 32'(vecs[i].data));
            end
            check($sformatf("vec%0d_row", i), 32'(cursor_row), 32'(vecs[i].row));
            check($sformatf("vec%0d_col", i), 32'(cursor_col), 32'(vecs[i].col));
        end

        // Full row 0 followed by wrap to (1,0).
        do_reset();
        for (int i = 0; i < 70; i++) begin
            send(8'h61 + 8'(i % 26));
            wait_idle();
        end
        begin
            int bad = 0;
            for (int i = 0; i < 70; i++) begin
                if (log_q[i] !== wr_t'({20'(4 + i), 8'h61 + 8'(i % 26)})) bad++;
            end
            check("row0_nwr",  32'(log_q.size()), 32'd70);
            check("row0_bad",  32'(bad),          32'd0);
            check("row0_last", 32'(log_q[69].addr), 32'd73);
            check("row0_wrap_row", 32'(cursor_row), 32'd1);
            check("row0_wrap_col", 32'(cursor_col), 32'd0);
        end

        // Move to (29,5) then LF: first scroll.
        for (int i = 0; i < 28; i++) begin
            send(CH_LF);
            wait_idle();
        end
        for (int i = 0; i < 5; i++) begin
            send(8'h30 + 8'(i));
            wait_idle();
        end
        check("pre_scroll_row", 32'(cursor_row), 32'd29);
        check("pre_scroll_col", 32'(cursor_col), 32'd5);
        check("pre_scroll_last_addr", 32'(log_q[log_q.size() - 1].addr), 32'd3720);
        log_q.delete();
        send(CH_LF);
        wait_idle();
        check("scroll1_nwr",  32'(log_q.size()), 32'd71);
        check("scroll1_reg",  32'(log_q[0]),     32'(wr_t'({20'd0, 8'd1})));
        check_blank_row("scroll1_blank", 1, 4);
        check("scroll1_row",  32'(cursor_row),   32'd29);
        check("scroll1_col",  32'(cursor_col),   32'd0);
        check("scroll1_zl",   32'(zero_line),    32'd1);

        // Bring zero_line to 29, then wrap it to 0.
        for (int i = 0; i < 28; i++) begin
            send(CH_LF);
            wait_idle();
        end
        check("zl29", 32'(zero_line), 32'd29);
        log_q.delete();
        send(CH_LF);
        wait_idle();
        check("wrap_nwr", 32'(log_q.size()), 32'd71);
        check("wrap_reg", 32'(log_q[0]),     32'(wr_t'({20'd0, 8'd0})));
        check_blank_row("wrap_blank", 1, 3716);
        check("wrap_zl",  32'(zero_line),    32'd0);
        log_q.delete();
        send(8'h42);
        wait_idle();
        check("b_nwr", 32'(log_q.size()), 32'd1);
        check("b_wr",  32'(log_q[0]),     32'(wr_t'({20'd3716, 8'h42})));
        check("b_col", 32'(cursor_col),   32'd1);

        // Printable in the last cell of the last row triggers a scroll.
        for (int i = 0; i < 68; i++) begin
            send(8'h63);
            wait_idle();
        end
        check("edge_col", 32'(cursor_col), 32'd69);
        log_q.delete();
        send(8'h5A);
        wait_idle();
        check("edge_nwr",   32'(log_q.size()), 32'd72);
        check("edge_char",  32'(log_q[0]),     32'(wr_t'({20'd3785, 8'h5A})));
        check("edge_reg",   32'(log_q[1]),     32'(wr_t'({20'd0, 8'd1})));
        check_blank_row("edge_blank", 2, 4);
        check("edge_row",   32'(cursor_row),   32'd29);
        check("edge_col0",  32'(cursor_col),   32'd0);
        check("edge_zl",    32'(zero_line),    32'd1);

        // Form feed: register write then full-screen blank, row-major.
        log_q.delete();
        send(CH_FF);
        wait_idle();
        check("ff_nwr", 32'(log_q.size()), 32'd2101);
        check("ff_reg", 32'(log_q[0]),     32'(wr_t'({20'd0, 8'd0})));
        begin
            int bad = 0;
            for (int r = 0; r < 30; r++) begin
                for (int c = 0; c < 70; c++) begin
                    if (log_q[1 + r * 70 + c] !== wr_t'({20'(4 + r * 128 + c), BLANK})) bad++;
                end
            end
            check("ff_fill_bad", 32'(bad), 32'd0);
        end
        check("ff_row", 32'(cursor_row), 32'd0);
        check("ff_col", 32'(cursor_col), 32'd0);
        check("ff_zl",  32'(zero_line),  32'd0);

        // Reset in the middle of a clear aborts it at once.
        send(CH_FF);
        repeat (100) @(negedge clk);
        check("midclr_busy", 32'(bus.we), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midclr_we",    32'(bus.we),         32'd0);
        check("midclr_ready", 32'(bus.char_ready), 32'd1);
        rst = 1'b0;
        log_q.delete();
        repeat (20) @(negedge clk);
        #1;
        check("midclr_quiet", 32'(log_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
